fib_batch_sequencer: RTL and testbench

//  Initiator side of the fibonacci core's start/finish handshake. Accepts a range command [first..last],

---
 rtl/fib_pkg.sv | 15 +
 rtl/fib_watchdog.sv | 35 +++
 rtl/fib_batch_sequencer.sv | 136 +++++++++++++
 tb/tb_fib_batch_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and defaults for the fibonacci batch sequencer.
package fib_pkg;

  localparam int unsigned N_W_DEF   = 5;
  localparam int unsigned RES_W_DEF = 128;
  localparam int unsigned FIB_MAX_N = 31;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StHold
  } state_e;

endpackage

// File: rtl/fib_watchdog.sv
// WAIT-state watchdog: counts cycles spent waiting on the core and flags expiry at TIMEOUT-1.
module fib_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = run && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && !expired) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fib_batch_sequencer.sv
// Drives a fibonacci core over a range [first..last] and streams (N, F(N)) beats on valid/ready.
// Optional WAIT timeout watchdog enabled by defining FIB_TIMEOUT_EN.
module fib_batch_sequencer
  import fib_pkg::*;
#(
  parameter int unsigned N_W     = N_W_DEF,
  parameter int unsigned RES_W   = RES_W_DEF,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N_W-1:0]   cmd_first,
  input  logic [N_W-1:0]   cmd_last,
  output logic             fib_start,
  output logic [N_W-1:0]   fib_n,
  input  logic             fib_finish,
  input  logic [RES_W-1:0] fib_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_W-1:0]   out_n,
  output logic [RES_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  state_e           state_q, state_d;
  logic [N_W-1:0]   cur_q, cur_d;
  logic [N_W-1:0]   last_q, last_d;
  logic             guard_q, guard_d;
  logic             err_q, err_d;
  logic [N_W-1:0]   out_n_q;
  logic [RES_W-1:0] out_data_q;
  logic             out_last_q;
  logic             capture;
  logic             expired;

`ifdef FIB_TIMEOUT_EN
  fib_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == StIssue),
    .run     (state_q == StWait),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    guard_d   = guard_q;
    err_d     = err_q;
    capture   = 1'b0;
    fib_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cur_d  = cmd_first;
          last_d = cmd_last;
          err_d  = 1'b0;
          if (cmd_first <= cmd_last) begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        fib_start = 1'b1;
        guard_d   = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        // First WAIT cycle still sees the core's finish from the previous run.
        guard_d = 1'b0;
        if (!guard_q && fib_finish) begin
          capture = 1'b1;
          state_d = StHold;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StHold: begin
        if (out_ready) begin
          if (cur_q == last_q) begin
            state_d = StIdle;
          end else begin
            cur_d   = cur_q + N_W'(1);
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      last_q     <= '0;
      guard_q    <= 1'b0;
      err_q      <= 1'b0;
      out_n_q    <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      guard_q <= guard_d;
      err_q   <= err_d;
      if (capture) begin
        out_n_q    <= cur_q;
        out_data_q <= fib_result;
        out_last_q <= (cur_q == last_q);
      end
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StHold);
  assign fib_n     = cur_q;
  assign out_n     = out_n_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fib_batch_sequencer.sv
// Directed bench for fib_batch_sequencer with a behavioural fibonacci core stub.
module tb_fib_batch_sequencer;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [4:0]   cmd_first;
  logic [4:0]   cmd_last;
  logic         fib_start;
  logic [4:0]   fib_n;
  logic         fib_finish;
  logic [127:0] fib_result;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_n;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  bit core_dead = 1'b0;

  logic [4:0]   bn[$];
  logic [127:0] bd[$];
  logic         bl[$];

  always #5 clk = ~clk;

  fib_batch_sequencer #(
    .N_W     (5),
    .RES_W   (128),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_first  (cmd_first),
    .cmd_last   (cmd_last),
    .fib_start  (fib_start),
    .fib_n      (fib_n),
    .fib_finish (fib_finish),
    .fib_result (fib_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_n      (out_n),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err)
  );

  // Core stub: finish stays high (stale) until the cycle after start, then LAT cycles to result.
  function automatic logic [127:0] fibf(input logic [4:0] n);
    logic [127:0] a, b, t;
    a = '0;
    b = 128'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  logic       start_d;
  logic [4:0] n_l;
  int         cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fib_finish <= 1'b1;
      fib_result <= '1;
      start_d    <= 1'b0;
      n_l        <= '0;
      cnt        <= 0;
    end else begin
      start_d <= fib_start;
      if (fib_start) n_l <= fib_n;
      if (start_d) begin
        fib_finish <= 1'b0;
        cnt        <= LAT;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1 && !core_dead) begin
          fib_finish <= 1'b1;
          fib_result <= fibf(n_l);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst && fib_start) starts <= starts + 1;
    if (rst && out_valid && out_ready) begin
      bn.push_back(out_n);
      bd.push_back(out_data);
      bl.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    bn.delete();
    bd.delete();
    bl.delete();
    starts = 0;
  endtask

  task automatic issue_cmd(input logic [4:0] first, input logic [4:0] last);
    cmd_valid = 1'b1;
    cmd_first = first;
    cmd_last  = last;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 1000) begin
      tick(1);
      k++;
    end
    check(tag, busy, 0);
  endtask

  task automatic check_beat(input int i, input logic [4:0] n, input logic [127:0] d,
                            input logic l);
    if (i < bn.size()) begin
      check($sformatf("beat%0d_n", i), bn[i], n);
      check($sformatf("beat%0d_data", i), bd[i], d);
      check($sformatf("beat%0d_last", i), bl[i], l);
    end else begin
      check($sformatf("beat%0d_present", i), bn.size(), i + 1);
    end
  endtask

  logic [127:0] exp_f [6];

  initial begin
    int k;
    exp_f = '{128'd0, 128'd1, 128'd1, 128'd2, 128'd3, 128'd5};
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_first = '0;
    cmd_last  = '0;
    out_ready = 1'b1;
    tick(3);

    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_fib_start", fib_start, 0);
    check("rst_out_n", out_n, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    tick(2);

    // 1: range 0..5
    clear_log();
    issue_cmd(5'd0, 5'd5);
    wait_idle("t1_done");
    check("t1_beats", bn.size(), 6);
    for (int i = 0; i < 6; i++) check_beat(i, 5'(i), exp_f[i], (i == 5));
    check("t1_starts", starts, 6);

    // 2: single beat at max N
    clear_log();
    issue_cmd(5'd31, 5'd31);
    wait_idle("t2_done");
    check("t2_beats", bn.size(), 1);
    check_beat(0, 5'd31, 128'd1346269, 1'b1);
    tick(3);
    check("t2_starts", starts, 1);
    check("t2_cmd_ready", cmd_ready, 1);

    // 3: empty range
    clear_log();
    issue_cmd(5'd7, 5'd3);
    check("t3_cmd_ready", cmd_ready, 1);
    check("t3_busy", busy, 0);
    tick(5);
    check("t3_starts", starts, 0);
    check("t3_beats", bn.size(), 0);

    // 4: backpressure on first beat
    clear_log();
    out_ready = 1'b0;
    issue_cmd(5'd2, 5'd3);
    k = 0;
    while (!out_valid && k < 100) begin
      tick(1);
      k++;
    end
    check("t4_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_n", out_n, 2);
      check("t4_hold_data", out_data, 1);
      check("t4_hold_starts", starts, 1);
      tick(1);
    end
    out_ready = 1'b1;
    wait_idle("t4_done");
    check("t4_beats", bn.size(), 2);
    check_beat(0, 5'd2, 128'd1, 1'b0);
    check_beat(1, 5'd3, 128'd2, 1'b1);

    // 5: async reset during WAIT
    clear_log();
    issue_cmd(5'd10, 5'd20);
    tick(1);
    #2 rst = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_out_n", out_n, 0);
    check("t5_out_data", out_data, 0);
    check("t5_fib_n", fib_n, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    clear_log();
    issue_cmd(5'd4, 5'd4);
    wait_idle("t5_done");
    check("t5_beats", bn.size(), 1);
    check_beat(0, 5'd4, 128'd3, 1'b1);

`ifdef FIB_TIMEOUT_EN
    // 6: core never finishes
    clear_log();
    core_dead = 1'b1;
    issue_cmd(5'd1, 5'd3);
    tick(1);
    tick(15);
    check("t6_err_early", err, 0);
    check("t6_busy_early", busy, 1);
    tick(1);
    check("t6_err", err, 1);
    check("t6_busy", busy, 0);
    check("t6_beats", bn.size(), 0);
    tick(2);
    check("t6_err_sticky", err, 1);
    core_dead = 1'b0;
    issue_cmd(5'd5, 5'd5);
    check("t6_err_clear", err, 0);
    wait_idle("t6_done");
    check_beat(0, 5'd5, 128'd5, 1'b1);
`else
    check("err_tied", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
